// File: rtl/queue_ctrl_2x123.sv
// 2-entry ready/valid FIFO control over ram_2x123; 1-cycle enq->deq latency, enq_ready=!full (no deq_ready path).
// Optional QUEUE_FLOW_EN: zero-latency combinational bypass when empty.
module queue_ctrl_2x123 #(
  parameter int WIDTH = 123,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [1:0]       count,
  output logic             ram_W0_addr,
  output logic             ram_W0_en,
  output logic [WIDTH-1:0] ram_W0_data,
  output logic             ram_R0_addr,
  output logic             ram_R0_en,
  input  logic [WIDTH-1:0] ram_R0_data
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("queue_ctrl_2x123 supports DEPTH=2 only");
  end

  logic enq_ptr, deq_ptr, maybe_full;
  logic ptr_match, empty, full;
  logic do_enq, do_deq, flow_thru, upd_enq, upd_deq;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;

  always_comb begin
    enq_ready = ~full;
`ifdef QUEUE_FLOW_EN
    // Bypass: an empty queue forwards the incoming payload straight to deq.
    deq_valid = ~reset & (~empty | enq_valid);
    deq_bits  = empty ? enq_bits : ram_R0_data;
`else
    deq_valid = ~reset & ~empty;
    deq_bits  = ram_R0_data;
`endif
    do_enq    = enq_valid & enq_ready & ~reset;
    do_deq    = deq_valid & deq_ready;
`ifdef QUEUE_FLOW_EN
    flow_thru = empty & do_enq & do_deq;
`else
    flow_thru = 1'b0;
`endif
    upd_enq   = do_enq & ~flow_thru;
    upd_deq   = do_deq & ~flow_thru;
  end

  assign count       = {full, enq_ptr ^ deq_ptr};
  assign ram_W0_addr = enq_ptr;
  assign ram_W0_en   = upd_enq;
  assign ram_W0_data = enq_bits;
  assign ram_R0_addr = deq_ptr;
  assign ram_R0_en   = deq_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= 1'b0;
      deq_ptr    <= 1'b0;
      maybe_full <= 1'b0;
    end else begin
      if (upd_enq) enq_ptr <= ~enq_ptr;
      if (upd_deq) deq_ptr <= ~deq_ptr;
      if (upd_enq != upd_deq) maybe_full <= upd_enq;
    end
  end

endmodule

// File: tb/tb_queue_ctrl_2x123.sv
module tb_queue_ctrl_2x123;
  localparam int W = 123;

  logic         clock = 1'b0;
  logic         reset;
  logic         enq_valid;
  logic         enq_ready;
  logic [W-1:0] enq_bits;
  logic         deq_valid;
  logic         deq_ready;
  logic [W-1:0] deq_bits;
  logic [1:0]   count;
  logic         ram_W0_addr, ram_W0_en, ram_R0_addr, ram_R0_en;
  logic [W-1:0] ram_W0_data, ram_R0_data;

  logic [W-1:0] mem [2];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q[$];
  int           wr_slot = 0;
  int           rd_slot = 0;
`ifdef QUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  always #5 clock = ~clock;

  always_ff @(posedge clock) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  assign ram_R0_data = mem[ram_R0_addr];

  queue_ctrl_2x123 dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .ram_W0_addr(ram_W0_addr), .ram_W0_en(ram_W0_en), .ram_W0_data(ram_W0_data),
    .ram_R0_addr(ram_R0_addr), .ram_R0_en(ram_R0_en), .ram_R0_data(ram_R0_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check outputs against the queue model, then clock.
  task automatic step(input logic ev, input logic [W-1:0] eb, input logic dr, input logic rst);
    int           n;
    logic         e_ready, e_valid, fire_enq, fire_deq, thru;
    logic [W-1:0] e_bits;
    enq_valid = ev; enq_bits = eb; deq_ready = dr; reset = rst;
    #1;
    n        = model_q.size();
    e_ready  = (n < 2);
    thru     = FLOW && (n == 0) && ev;
    e_valid  = !rst && ((n > 0) || thru);
    e_bits   = (n > 0) ? model_q[0] : eb;
    fire_enq = ev && e_ready && !rst;
    fire_deq = e_valid && dr;
    check("deq_valid", deq_valid, e_valid);
    check("ram_W0_en", ram_W0_en, fire_enq && !(thru && dr));
    check("ram_R0_en", ram_R0_en, e_valid);
    if (!rst) begin
      check("count", count, n);
      check("enq_ready", enq_ready, e_ready);
      if (e_valid) check("deq_bits", deq_bits, e_bits);
      if (fire_enq && !(thru && dr)) check("ram_W0_addr", ram_W0_addr, wr_slot[0]);
      if (e_valid && n > 0) check("ram_R0_addr", ram_R0_addr, rd_slot[0]);
      if (fire_enq) check("ram_W0_data", ram_W0_data, eb);
    end
    @(posedge clock);
    if (rst) begin
      model_q.delete(); wr_slot = 0; rd_slot = 0;
    end else if (!(thru && dr)) begin
      if (fire_deq) begin void'(model_q.pop_front()); rd_slot++; end
      if (fire_enq) begin model_q.push_back(eb); wr_slot++; end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [W-1:0] rnd;
    reset = 1'b1; enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;
    @(negedge clock);
    // 1. reset, idle
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // 2. fill with 1, 2
    step(1'b1, W'(1), 1'b0, 1'b0);
    step(1'b1, W'(2), 1'b0, 1'b0);
    step(1'b1, W'(3), 1'b0, 1'b0);   // full: must be refused
    // 3. drain
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // 4. hold count=1 with simultaneous enq/deq
    step(1'b1, W'(9), 1'b0, 1'b0);
    for (int i = 10; i <= 14; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // 5. reset at count=2
    step(1'b1, W'(4), 1'b0, 1'b0);
    step(1'b1, W'(5), 1'b0, 1'b0);
    step(1'b1, W'(6), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, W'(7), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // 6. enq into empty queue with deq_ready=1 (bypass when enabled)
    step(1'b1, W'(5), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 2) != 0), rnd, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 60) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
